alu_operand_loader: RTL
=======================

Name: alu_operand_loader

Overview:
- Input-side front end for the ALU board harness. Sits between the board buttons/switches and an alu_if instance.
- Debounces push-buttons and steps the user through entering operand A, operand B and the ALU opcode from SW.
- Drives port_a, port_b and aluop into the ALU, and flags when a complete, stable operation is presented.
- It is the writer of the ALU input bundle; the existing display path is its reader.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples needed before a button level is accepted (bench uses 4).
- CNT_W, 16, width of debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  synchronous active-low reset.
- KEY  input  4  board push-buttons, active-low; KEY[0]=enter, KEY[1]=clear, KEY[2]=swap (optional feature), KEY[3] unused.
- SW  input  18  board switches; SW[16:0] operand entry, SW[3:0] opcode entry.
- port_a  output  32  operand A to ALU.
- port_b  output  32  operand B to ALU.
- aluop  output  4  ALU opcode (cast to aluop_t at the instantiation).
- op_valid  output  1  high while in RUN state.
- stage  output  2  current state encoding, for LEDs.

Behaviour:
- Reset: nRST sampled on rising CLK, active low, synchronous. While low: port_a=0, port_b=0, aluop=0, op_valid=0, stage=LOAD_A(2'b00), all synchronizers=1 (released), debounce counters=0. Reset mid-sequence aborts and returns to LOAD_A.
- Input conditioning:
  - Each KEY bit passes a 2-flop synchronizer.
  - Debounced level updates only after DEBOUNCE_CYCLES consecutive cycles with the synchronized value differing from the current debounced level; any glitch restarts the count at 0.
  - A press event is a single-cycle pulse on the debounced 1->0 transition. Releases generate no event.
  - Event latency from stable KEY low: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - SW is synchronized (2 flops) but not debounced.
- State machine (stage encoding): LOAD_A=00, LOAD_B=01, LOAD_OP=10, RUN=11.
  - LOAD_A + enter: port_a <= {{15{SW[16]}},SW[16:0]} (sign-extend bit 16); go LOAD_B.
  - LOAD_B + enter: port_b <= same sign-extension of SW; go LOAD_OP.
  - LOAD_OP + enter: aluop <= SW[3:0]; go RUN; op_valid=1 from the next cycle.
  - RUN + enter: op_valid<=0; go LOAD_A. Registers keep their values until overwritten.
  - Clear event in any state: port_a, port_b, aluop <= 0; op_valid <= 0; go LOAD_A.
- Register behaviour:
  - port_a, port_b and aluop change only on their own load edge; they are otherwise held stable. No combinational path from SW to outputs.
  - op_valid is registered and equals (stage==RUN).
- Simultaneous events: clear has priority over enter and swap. Enter has priority over swap.
- Holding a button produces exactly one event; a new event requires a release followed by a new press.

Optional Feature:
- Macro ALU_LOADER_SWAP_EN.
- Defined: a swap event (KEY[2]) in RUN exchanges port_a and port_b in one cycle. op_valid stays 1 and stage is unchanged. Swap in any other state is ignored.
- Undefined: KEY[2] is not synchronized or debounced and has no effect. Its logic is absent.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold nRST=0 for 3 cycles with KEY=4'b1111 -> all outputs 0, stage=00. Release -> outputs unchanged.
- Full sequence:
  - SW=18'h00005, press enter -> port_a=32'h00000005, stage=01.
  - SW=18'h1FFFF, press enter -> port_b=32'hFFFFFFFF, stage=10.
  - SW=18'h00002, press enter -> aluop=4'h2, stage=11, op_valid=1.
  - Press enter again -> stage=00, op_valid=0, values retained.
- Bounce: toggle KEY[0] low/high every 2 cycles for 20 cycles, then hold low 10 cycles -> exactly one enter event. A 3-cycle low glitch -> no event.
- Clear priority: in LOAD_OP press KEY[0] and KEY[1] together -> port_a=port_b=aluop=0, stage=00, no load.
- Reset mid-sequence: in LOAD_B pulse nRST=0 for 1 cycle -> stage=00 and port_a=0 on the next edge.
- Swap (ALU_LOADER_SWAP_EN): in RUN with A=5, B=32'hFFFFFFFF, press KEY[2] -> A=32'hFFFFFFFF, B=5, op_valid=1. Without the macro -> no change.

Source files
------------

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced button/switch front end loading ALU operands.
// Define ALU_LOADER_SWAP_EN to enable the KEY[2] operand swap in RUN.
module alu_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [3:0]  KEY,
   input  logic [17:0] SW,
   output logic [31:0] port_a,
   output logic [31:0] port_b,
   output logic [3:0]  aluop,
   output logic        op_valid,
   output logic [1:0]  stage
);

`ifdef ALU_LOADER_SWAP_EN
   localparam int NK = 3;
`else
   localparam int NK = 2;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      RUN     = 2'b11
   } state_t;

   state_t           state;
   logic [NK-1:0]    k_s1;
   logic [NK-1:0]    k_s2;
   logic [NK-1:0]    k_deb;
   logic [NK-1:0]    press;
   logic [CNT_W-1:0] cnt [NK];
   logic [16:0]      sw_s1;
   logic [16:0]      sw_s2;
   logic [31:0]      sw_ext;
   logic             enter;
   logic             clear;
   logic             unused;

   assign enter  = press[0];
   assign clear  = press[1];
   assign sw_ext = {{15{sw_s2[16]}}, sw_s2};
   assign stage  = state;
   assign unused = ^{KEY[3:NK], SW[17]};

`ifdef ALU_LOADER_SWAP_EN
   logic swap;
   assign swap = press[2];
`endif

   // two-flop synchronizers for the used keys and the switches
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         k_s1  <= '1;
         k_s2  <= '1;
         sw_s1 <= '1;
         sw_s2 <= '1;
      end else begin
         k_s1  <= KEY[NK-1:0];
         k_s2  <= k_s1;
         sw_s1 <= SW[16:0];
         sw_s2 <= sw_s1;
      end
   end

   // debounce each key; pulse press on the accepted 1->0 transition
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         k_deb <= '1;
         press <= '0;
         for (int i = 0; i < NK; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NK; i++) begin
            press[i] <= 1'b0;
            if (k_s2[i] == k_deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               cnt[i]   <= '0;
               k_deb[i] <= k_s2[i];
               press[i] <= k_deb[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // operand entry sequencer; clear beats enter, enter beats swap
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= LOAD_A;
         port_a   <= '0;
         port_b   <= '0;
         aluop    <= '0;
         op_valid <= 1'b0;
      end else if (clear) begin
         state    <= LOAD_A;
         port_a   <= '0;
         port_b   <= '0;
         aluop    <= '0;
         op_valid <= 1'b0;
      end else if (enter) begin
         unique case (state)
            LOAD_A: begin
               port_a <= sw_ext;
               state  <= LOAD_B;
            end
            LOAD_B: begin
               port_b <= sw_ext;
               state  <= LOAD_OP;
            end
            LOAD_OP: begin
               aluop    <= sw_s2[3:0];
               op_valid <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               op_valid <= 1'b0;
               state    <= LOAD_A;
            end
         endcase
`ifdef ALU_LOADER_SWAP_EN
      end else if (swap && state == RUN) begin
         port_a <= port_b;
         port_b <= port_a;
`endif
      end
   end

endmodule
